// File: rtl/temp_ctrl_fsm.sv
// Thermostat stage: captures DHT11 samples, smooths temperature and drives fan/heater
// through a hysteresis FSM with dwell and stale-sensor watchdog. Define TEMP_CTRL_AVG_EN for the 4-sample window.
`timescale 1ns/1ps
module temp_ctrl_fsm #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter logic [7:0]  HYST        = 8'd2,
    parameter int unsigned MIN_DWELL_S = 5,
    parameter int unsigned STALE_S     = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       done_i,
    input  logic [7:0] temp_i,
    input  logic [7:0] hum_i,
    input  logic [7:0] setpoint_i,
    output logic       fan_o,
    output logic       heater_o,
    output logic       fault_o,
    output logic [7:0] temp_avg_o,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOL  = 2'd1,
        HEAT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DW = (MIN_DWELL_S > 0) ? $clog2(MIN_DWELL_S + 1) : 1;
    localparam int unsigned SW = (STALE_S > 0) ? $clog2(STALE_S + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL_S);
    localparam logic [SW-1:0] STALE_MAX  = SW'(STALE_S);

    logic          r_done_q;
    logic [PW-1:0] r_presc;
    logic [DW-1:0] r_dwell;
    logic [SW-1:0] r_stale;
    logic          r_upd;
    logic          r_bad;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_fan;
    logic          r_heater;
    logic          r_fault;

    logic          w_tick;
    logic          w_accept;
    logic          w_valid_in;
    logic          w_take;
    logic          w_stale_hit;
    logic [8:0]    w_hi;
    logic [7:0]    w_lo;
    logic [7:0]    w_avg;

    assign w_tick      = (r_presc == PRESC_MAX);
    assign w_accept    = done_i && !r_done_q;
    assign w_valid_in  = (temp_i <= 8'd60) && (hum_i <= 8'd100);
    assign w_take      = w_accept && w_valid_in;
    assign w_hi        = {1'b0, setpoint_i} + {1'b0, HYST};
    assign w_lo        = (setpoint_i > HYST) ? (setpoint_i - HYST) : 8'd0;
    // A sample landing on the expiry cycle keeps the sensor alive.
    assign w_stale_hit = (r_stale == STALE_MAX) && !w_accept && (r_state != FAULT);

`ifdef TEMP_CTRL_AVG_EN
    logic [7:0] r_win [4];
    logic       r_win_full;
    logic [9:0] w_sum;

    assign w_sum = 10'(r_win[0]) + 10'(r_win[1]) + 10'(r_win[2]) + 10'(r_win[3]);
    assign w_avg = r_win_full ? 8'(w_sum >> 2) : 8'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_win_full <= 1'b0;
        end else if (w_take) begin
            r_win_full <= 1'b1;
        end
    end

    // NOTE: window data has no reset; r_win_full masks it until the first sample fills all four slots.
    always_ff @(posedge clk_i) begin
        if (w_take) begin
            r_win[0] <= temp_i;
            for (int i = 1; i < 4; i++) begin
                r_win[i] <= r_win_full ? r_win[i-1] : temp_i;
            end
        end
    end
`else
    logic [7:0] r_last;

    assign w_avg = r_last;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= 8'd0;
        end else if (w_take) begin
            r_last <= temp_i;
        end
    end
`endif

    // NOTE: default assignment first, so every path drives w_state_nxt and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        if (r_bad || w_stale_hit) begin
            w_state_nxt = FAULT;
        end else if (r_upd) begin
            if (r_state == FAULT) begin
                w_state_nxt = IDLE;
            end else if (r_dwell == '0) begin
                case (r_state)
                    IDLE: begin
                        if ({1'b0, w_avg} > w_hi)  w_state_nxt = COOL;
                        else if (w_avg < w_lo)     w_state_nxt = HEAT;
                    end
                    COOL:    if (w_avg <= setpoint_i) w_state_nxt = IDLE;
                    HEAT:    if (w_avg >= setpoint_i) w_state_nxt = IDLE;
                    default: w_state_nxt = r_state;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_done_q <= 1'b1;
            r_presc  <= '0;
            r_dwell  <= '0;
            r_stale  <= '0;
            r_upd    <= 1'b0;
            r_bad    <= 1'b0;
            r_state  <= IDLE;
            r_fan    <= 1'b0;
            r_heater <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_done_q <= done_i;
            r_presc  <= w_tick ? '0 : r_presc + PW'(1);
            r_upd    <= w_take;
            r_bad    <= w_accept && !w_valid_in;

            if (w_accept) begin
                r_stale <= '0;
            end else if (w_tick && (r_stale != STALE_MAX)) begin
                r_stale <= r_stale + SW'(1);
            end

            if (w_state_nxt != r_state) begin
                r_dwell <= DWELL_LOAD;
            end else if (w_tick && (r_dwell != '0)) begin
                r_dwell <= r_dwell - DW'(1);
            end

            r_state  <= w_state_nxt;
            r_fan    <= (w_state_nxt == COOL);
            r_heater <= (w_state_nxt == HEAT);
            r_fault  <= (w_state_nxt == FAULT);
        end
    end

    assign fan_o      = r_fan;
    assign heater_o   = r_heater;
    assign fault_o    = r_fault;
    assign temp_avg_o = w_avg;
    assign state_o    = r_state;

endmodule

// File: tb/tb_temp_ctrl_fsm.sv
// Directed bench for temp_ctrl_fsm: table of timed samples plus hand-written stale,
// coincident-expiry and held-done/reset sequences. Tracks TEMP_CTRL_AVG_EN for expected averages.
`timescale 1ns/1ps
module tb_temp_ctrl_fsm;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COOL  = 2'd1;
    localparam logic [1:0] S_HEAT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;
`ifdef TEMP_CTRL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic       clk_i      = 1'b0;
    logic       rst_i      = 1'b1;
    logic       done_i     = 1'b0;
    logic [7:0] temp_i     = 8'd0;
    logic [7:0] hum_i      = 8'd0;
    logic [7:0] setpoint_i = 8'd26;
    logic       fan_o;
    logic       heater_o;
    logic       fault_o;
    logic [7:0] temp_avg_o;
    logic [1:0] state_o;

    temp_ctrl_fsm #(
        .CLK_HZ     (1000),
        .HYST       (8'd2),
        .MIN_DWELL_S(2),
        .STALE_S    (3)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .done_i    (done_i),
        .temp_i    (temp_i),
        .hum_i     (hum_i),
        .setpoint_i(setpoint_i),
        .fan_o     (fan_o),
        .heater_o  (heater_o),
        .fault_o   (fault_o),
        .temp_avg_o(temp_avg_o),
        .state_o   (state_o)
    );

    always #5 clk_i = ~clk_i;

    // Rising edges since reset release; the 1 s tick lands on every multiple of 1000.
    int unsigned edge_cnt = 0;
    always @(posedge clk_i) begin
        if (rst_i) edge_cnt <= 0;
        else       edge_cnt <= edge_cnt + 1;
    end

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic [1:0]  cur_state = S_IDLE;

    typedef struct {
        bit          rst;
        int unsigned k;
        logic [7:0]  t;
        logic [7:0]  h;
        logic [7:0]  avg;
        logic [1:0]  st;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic logic [7:0] pk(input logic [7:0] en, input logic [7:0] dis);
        return AVG_EN ? en : dis;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    // Returns at the falling edge just before rising edge k.
    task automatic goto_edge(input int unsigned k);
        check($sformatf("schedule to edge %0d", k), 32'(edge_cnt < k), 32'd1);
        while (edge_cnt + 1 < k) @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        cur_state = S_IDLE;
    endtask

    task automatic apply(input int unsigned k, input logic [7:0] t, input logic [7:0] h,
                         input logic [7:0] avg, input logic [1:0] st);
        goto_edge(k);
        temp_i = t;
        hum_i  = h;
        done_i = 1'b1;
        @(negedge clk_i);
        temp_i = 8'd55;
        check($sformatf("avg N+1 (edge %0d)", k), 32'(temp_avg_o), 32'(avg));
        check($sformatf("state N+1 (edge %0d)", k), 32'(state_o), 32'(cur_state));
        @(negedge clk_i);
        check($sformatf("state N+2 (edge %0d)", k), 32'(state_o), 32'(st));
        check("fan_o", 32'(fan_o), 32'(st == S_COOL));
        check("heater_o", 32'(heater_o), 32'(st == S_HEAT));
        check("fault_o", 32'(fault_o), 32'(st == S_FAULT));
        cur_state = st;
        repeat (2) @(negedge clk_i);
        done_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit exceeded");
        $fatal(1, "timeout");
    end

    initial begin
        // Averaging and hysteresis from a fresh reset.
        vecs[0]  = '{1'b1,  1500, 8'd30, 8'd50, pk(30, 30), S_COOL};
        vecs[1]  = '{1'b0,  3500, 8'd30, 8'd50, pk(30, 30), S_COOL};
        vecs[2]  = '{1'b0,  5500, 8'd24, 8'd50, pk(28, 24), AVG_EN ? S_COOL : S_IDLE};
        vecs[3]  = '{1'b0,  7500, 8'd24, 8'd50, pk(27, 24), AVG_EN ? S_COOL : S_IDLE};
        vecs[4]  = '{1'b0,  9500, 8'd24, 8'd50, pk(25, 24), S_IDLE};
        vecs[5]  = '{1'b0, 11500, 8'd24, 8'd50, pk(24, 24), S_IDLE};
        // Dwell, range faults and fault exit.
        vecs[6]  = '{1'b1,  1500, 8'd29, 8'd50, pk(29, 29), S_COOL};
        vecs[7]  = '{1'b0,  2500, 8'd20, 8'd50, pk(26, 20), S_COOL};
        vecs[8]  = '{1'b0,  4500, 8'd20, 8'd50, pk(24, 20), S_IDLE};
        vecs[9]  = '{1'b0,  5500, 8'd20, 8'd50, pk(22, 20), S_IDLE};
        vecs[10] = '{1'b0,  7500, 8'd20, 8'd50, pk(20, 20), S_HEAT};
        vecs[11] = '{1'b0,  9500, 8'd61, 8'd40, pk(20, 20), S_FAULT};
        vecs[12] = '{1'b0, 10500, 8'd30, 8'd50, pk(22, 30), S_IDLE};
        vecs[13] = '{1'b0, 12500, 8'd20, 8'd101, pk(22, 30), S_FAULT};
        vecs[14] = '{1'b0, 13500, 8'd20, 8'd50, pk(22, 20), S_IDLE};

        do_reset();
        check("reset state_o", 32'(state_o), 32'(S_IDLE));
        check("reset fan_o", 32'(fan_o), 32'd0);
        check("reset heater_o", 32'(heater_o), 32'd0);
        check("reset fault_o", 32'(fault_o), 32'd0);
        check("reset temp_avg_o", 32'(temp_avg_o), 32'd0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].rst) do_reset();
            apply(vecs[i].k, vecs[i].t, vecs[i].h, vecs[i].avg, vecs[i].st);
        end

        // Stale watchdog: last sample at edge 13500, third tick afterwards is edge 16000.
        goto_edge(15501);
        check("stale 2 ticks state_o", 32'(state_o), 32'(S_IDLE));
        goto_edge(16501);
        check("stale state_o", 32'(state_o), 32'(S_FAULT));
        check("stale fault_o", 32'(fault_o), 32'd1);
        check("stale fan_o", 32'(fan_o), 32'd0);
        check("stale heater_o", 32'(heater_o), 32'd0);
        cur_state = S_FAULT;
        apply(17500, 8'd20, 8'd50, pk(22, 20), S_IDLE);
        // Sample on the very tick that would expire the watchdog.
        apply(20000, 8'd20, 8'd50, pk(22, 20), S_HEAT);
        goto_edge(22501);
        check("post-coincide state_o", 32'(state_o), 32'(S_HEAT));
        check("post-coincide fault_o", 32'(fault_o), 32'd0);

        // Held done_i: one acceptance, then reset while held.
        do_reset();
        goto_edge(1500);
        temp_i = 8'd30;
        hum_i  = 8'd50;
        done_i = 1'b1;
        @(negedge clk_i);
        temp_i = 8'd50;
        check("held avg N+1", 32'(temp_avg_o), 32'd30);
        repeat (499) @(negedge clk_i);
        check("held avg after 500", 32'(temp_avg_o), 32'd30);
        check("held state_o", 32'(state_o), 32'(S_COOL));
        check("held fan_o", 32'(fan_o), 32'd1);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        cur_state = S_IDLE;
        repeat (100) @(negedge clk_i);
        check("held-reset temp_avg_o", 32'(temp_avg_o), 32'd0);
        check("held-reset state_o", 32'(state_o), 32'(S_IDLE));
        check("held-reset fan_o", 32'(fan_o), 32'd0);
        done_i = 1'b0;
        apply(200, 8'd50, 8'd50, 8'd50, S_COOL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
